// File: rtl/swc_ingress_framer.sv
// Ingress framer: packs lookup-stage beats into 128-bit data-FIFO writes and closes
// each frame with one 16-bit descriptor {4'b0, portmap, word count}.
module swc_ingress_framer #(
    parameter int MAX_WORDS = 96
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] in_data,
    input  logic         in_valid,
    input  logic         in_sof,
    input  logic         in_eof,
    input  logic         in_err,
    input  logic [3:0]   in_portmap,
    input  logic [1:0]   in_src_port,
    output logic         in_ready,
    output logic [127:0] cell_data_din,
    output logic         cell_data_wr,
    output logic [15:0]  cell_ptr_din,
    output logic         cell_ptr_wr,
    input  logic         cell_bp,
    output logic [15:0]  stat_fwd_cnt,
    output logic [15:0]  stat_drop_cnt
);

    typedef enum logic [1:0] {IDLE, BODY, OVER} state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_WORDS);

    state_t      state, state_nxt;
    logic [7:0]  word_cnt, cnt_nxt;
    logic [3:0]  portmap_eff, pm_nxt;
    logic [3:0]  pm_in;
    logic        accept;
    logic        data_wr_nxt;
    logic        close_old, close_cur;
    logic [15:0] desc_old, desc_cur;
    logic        pend_vld, pend_vld_nxt;
    logic [15:0] pend_desc, pend_desc_nxt;
    logic        emit_vld;
    logic [15:0] emit_desc;

    function automatic logic [15:0] make_desc(input logic [3:0] pm, input logic [7:0] cnt,
                                              input logic discard);
        return {4'b0, discard ? 4'b0 : pm, cnt};
    endfunction

    assign in_ready = ~cell_bp;
    assign accept   = in_valid & ~cell_bp;
    assign pm_in    = in_portmap & ~(4'b0001 << in_src_port);

    // close_old retires a frame cut short by a new sof; close_cur retires the frame of this beat.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_nxt   = state;
        cnt_nxt     = word_cnt;
        pm_nxt      = portmap_eff;
        data_wr_nxt = 1'b0;
        close_old   = 1'b0;
        close_cur   = 1'b0;
        desc_old    = '0;
        desc_cur    = '0;
        if (accept) begin
            if (in_sof) begin
                if (state != IDLE) begin
                    close_old = 1'b1;
                    desc_old  = make_desc(portmap_eff, word_cnt, 1'b1);
                end
                data_wr_nxt = 1'b1;
                pm_nxt      = pm_in;
                cnt_nxt     = 8'd1;
                if (in_eof) begin
                    close_cur = 1'b1;
                    desc_cur  = make_desc(pm_in, 8'd1, in_err || pm_in == 4'b0);
                    state_nxt = IDLE;
                end else begin
                    state_nxt = BODY;
                end
            end else begin
                case (state)
                    BODY: begin
                        if (word_cnt == MAX_CNT) begin
                            if (in_eof) begin
                                close_cur = 1'b1;
                                desc_cur  = make_desc(portmap_eff, word_cnt, 1'b1);
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = OVER;
                            end
                        end else begin
                            data_wr_nxt = 1'b1;
                            cnt_nxt     = word_cnt + 8'd1;
                            if (in_eof) begin
                                close_cur = 1'b1;
                                desc_cur  = make_desc(portmap_eff, word_cnt + 8'd1,
                                                      in_err || portmap_eff == 4'b0);
                                state_nxt = IDLE;
                            end
                        end
                    end
                    OVER: begin
                        if (in_eof) begin
                            close_cur = 1'b1;
                            desc_cur  = make_desc(portmap_eff, word_cnt, 1'b1);
                            state_nxt = IDLE;
                        end
                    end
                    default: ;  // beats outside a frame are dropped
                endcase
            end
        end
    end

    // A sof+eof beat that cuts an open frame yields two descriptors; the younger one waits a
    // cycle in pend_desc. That only happens in BODY/OVER, and the slot always drains before the
    // FSM can leave IDLE again, so one entry is enough.
    always_comb begin
        emit_vld = pend_vld | close_old | close_cur;
        if (pend_vld) begin
            emit_desc     = pend_desc;
            pend_vld_nxt  = close_old | close_cur;
            pend_desc_nxt = close_old ? desc_old : desc_cur;
        end else begin
            emit_desc     = close_old ? desc_old : desc_cur;
            pend_vld_nxt  = close_old & close_cur;
            pend_desc_nxt = desc_cur;
        end
    end

    // NOTE: state is assigned non-blocking so every flop samples pre-edge values in parallel.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            word_cnt      <= '0;
            portmap_eff   <= '0;
            pend_vld      <= 1'b0;
            pend_desc     <= '0;
            cell_data_wr  <= 1'b0;
            cell_data_din <= '0;
            cell_ptr_wr   <= 1'b0;
            cell_ptr_din  <= '0;
            stat_fwd_cnt  <= '0;
            stat_drop_cnt <= '0;
        end else begin
            state        <= state_nxt;
            word_cnt     <= cnt_nxt;
            portmap_eff  <= pm_nxt;
            pend_vld     <= pend_vld_nxt;
            pend_desc    <= pend_desc_nxt;
            cell_data_wr <= data_wr_nxt;
            if (data_wr_nxt) cell_data_din <= in_data;
            cell_ptr_wr  <= emit_vld;
            if (emit_vld) begin
                cell_ptr_din <= emit_desc;
                if (emit_desc[11:8] != 4'b0) stat_fwd_cnt  <= stat_fwd_cnt + 16'd1;
                else                         stat_drop_cnt <= stat_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_swc_ingress_framer.sv
// Bench for swc_ingress_framer: directed scenarios plus randomized frames, checked against a
// frame-level reference model (open frame record, expected data word, descriptor queue).
module tb_swc_ingress_framer;

    localparam int MAX = 96;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_err = 1'b0;
    logic [3:0]   in_portmap = '0;
    logic [1:0]   in_src_port = '0;
    logic         in_ready;
    logic [127:0] cell_data_din;
    logic         cell_data_wr;
    logic [15:0]  cell_ptr_din;
    logic         cell_ptr_wr;
    logic         cell_bp = 1'b0;
    logic [15:0]  stat_fwd_cnt, stat_drop_cnt;

    swc_ingress_framer #(.MAX_WORDS(MAX)) dut (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_eof(in_eof), .in_err(in_err), .in_portmap(in_portmap), .in_src_port(in_src_port),
        .in_ready(in_ready), .cell_data_din(cell_data_din), .cell_data_wr(cell_data_wr),
        .cell_ptr_din(cell_ptr_din), .cell_ptr_wr(cell_ptr_wr), .cell_bp(cell_bp),
        .stat_fwd_cnt(stat_fwd_cnt), .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit           m_open;
    bit           m_over;
    int           m_nwr;
    logic [3:0]   m_pm;
    logic [15:0]  dq[$];
    int           m_fwd, m_drop;
    logic         exp_wr;
    logic [127:0] exp_din;
    bit           accepted;
    logic [15:0]  last_desc = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_close(input bit zero);
        logic [15:0] d;
        d = {4'b0, zero ? 4'b0 : m_pm, 8'(m_nwr)};
        dq.push_back(d);
        if (d[11:8] != 4'b0) m_fwd++;
        else m_drop++;
        m_open = 1'b0;
    endtask

    task automatic model_beat();
        if (in_sof) begin
            if (m_open) m_close(1'b1);
            m_open  = 1'b1;
            m_over  = 1'b0;
            m_nwr   = 1;
            m_pm    = in_portmap & ~(4'b0001 << in_src_port);
            exp_wr  = 1'b1;
            exp_din = in_data;
            if (in_eof) m_close(in_err || m_pm == 4'b0);
        end else if (m_open) begin
            if (m_nwr < MAX) begin
                m_nwr++;
                exp_wr  = 1'b1;
                exp_din = in_data;
            end else begin
                m_over = 1'b1;
            end
            if (in_eof) m_close(m_over || in_err || m_pm == 4'b0);
        end
    endtask

    task automatic step();
        #1;
        check("in_ready", in_ready, !cell_bp);
        accepted = in_valid && !cell_bp;
        @(posedge clk);
        exp_wr = 1'b0;
        if (accepted && rstn) model_beat();
        #1;
        check("data_wr", cell_data_wr, exp_wr);
        if (exp_wr) check("data_din", cell_data_din, exp_din);
        check("ptr_wr", cell_ptr_wr, dq.size() != 0);
        if (cell_ptr_wr && dq.size() != 0) begin
            check("ptr_din", cell_ptr_din, dq[0]);
            last_desc = cell_ptr_din;
            void'(dq.pop_front());
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit e, input bit er,
                         input logic [3:0] pm, input logic [1:0] src, input bit bp);
        in_valid    = v;
        in_sof      = s;
        in_eof      = e;
        in_err      = er;
        in_portmap  = pm;
        in_src_port = src;
        cell_bp     = bp;
        in_data     = {$urandom(), $urandom(), $urandom(), $urandom()};
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 2'd0, 1'b0);
    endtask

    task automatic send_frame(input int len, input logic [1:0] src, input logic [3:0] pm,
                              input bit err, input bit no_eof, input int bp_pct, input int gap_pct);
        for (int i = 0; i < len; i++) begin
            do begin
                drive($urandom_range(0, 99) >= gap_pct, i == 0, (i == len - 1) && !no_eof,
                      (i == len - 1) && err, pm, src, $urandom_range(0, 99) < bp_pct);
            end while (!accepted);
        end
        in_valid = 1'b0;
        cell_bp  = 1'b0;
    endtask

    task automatic check_stats(input string tag);
        idle(3);
        check({tag, "_fwd"}, stat_fwd_cnt, 16'(m_fwd));
        check({tag, "_drop"}, stat_drop_cnt, 16'(m_drop));
        check({tag, "_dq_empty"}, dq.size(), 0);
    endtask

    initial begin
        m_open = 1'b0; m_over = 1'b0; m_nwr = 0; m_pm = '0; m_fwd = 0; m_drop = 0;

        // Reset state
        idle(3);
        check("rst_data_wr", cell_data_wr, 0);
        check("rst_ptr_wr", cell_ptr_wr, 0);
        check("rst_data_din", cell_data_din, 0);
        check("rst_ptr_din", cell_ptr_din, 0);
        check("rst_fwd", stat_fwd_cnt, 0);
        check("rst_drop", stat_drop_cnt, 0);
        @(negedge clk);
        rstn = 1'b1;

        // First beat after reset without sof is dropped
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 2'd0, 1'b0);
        idle(2);

        // 5-word frame, src 0, portmap 0111
        send_frame(5, 2'd0, 4'b0111, 1'b0, 1'b0, 0, 0);
        idle(2);
        check("r029_desc", last_desc, 16'h0605);
        check("r029_fwd", stat_fwd_cnt, 16'd1);

        // Single-beat frame whose only destination is its own source port
        send_frame(1, 2'd2, 4'b0100, 1'b0, 1'b0, 0, 0);
        idle(2);
        check("r030_desc", last_desc, 16'h0001);
        check("r030_drop", stat_drop_cnt, 16'd1);

        // Oversize frame is truncated at MAX words
        send_frame(100, 2'd1, 4'b1111, 1'b0, 1'b0, 0, 0);
        idle(2);
        check("r031_desc", last_desc, 16'h0060);
        check("r031_drop", stat_drop_cnt, 16'd2);

        // Back-pressure stall mid-frame with valid held
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 1'b0, 4'b1111, 2'd3, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 2'd3, 1'b1);
        for (int i = 3; i < 8; i++) drive(1'b1, 1'b0, i == 7, 1'b0, 4'b1111, 2'd3, 1'b0);
        idle(2);
        check("r032_desc", last_desc, 16'h0708);
        check_stats("r032");

        // sof on word 3 of an open frame, then an errored frame
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 1'b0, 4'b0010, 2'd0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0);
        check("r033_cut_desc", last_desc, 16'h0003);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 2'd1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, 2'd1, 1'b0);
        idle(2);
        check("r033_err_desc", last_desc, 16'h0004);
        check_stats("r033");

        // Reset asserted mid-frame
        send_frame(4, 2'd2, 4'b1011, 1'b0, 1'b1, 0, 0);
        rstn = 1'b0;
        #1;
        check("r034_data_wr", cell_data_wr, 0);
        check("r034_ptr_wr", cell_ptr_wr, 0);
        check("r034_data_din", cell_data_din, 0);
        check("r034_ptr_din", cell_ptr_din, 0);
        check("r034_fwd", stat_fwd_cnt, 0);
        check("r034_drop", stat_drop_cnt, 0);
        dq.delete();
        m_open = 1'b0; m_fwd = 0; m_drop = 0;
        @(negedge clk);
        rstn = 1'b1;
        idle(2);
        send_frame(3, 2'd1, 4'b0011, 1'b0, 1'b0, 0, 0);
        idle(2);
        check("r034_next_desc", last_desc, 16'h0103);
        check_stats("r034");

        // Randomized frames: gaps, back-pressure, errors, truncated and stray beats
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 7) == 0)
                drive(1'b1, 1'b0, $urandom_range(0, 1) == 1, 1'b0, 4'hF, 2'd0, 1'b0);
            send_frame($urandom_range(1, 110), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, 20, 20);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'b1110, 2'd0, 1'b0);
        check_stats("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/swc_ingress_framer.md
SWC_INGRESS_FRAMER -- requirements
Module: swc_ingress_framer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 96, meaning the maximum number of 128-bit words per frame written to the cell FIFO (legal range 4..255).
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have port in_data, input, 128, frame word from the lookup stage.
REQ-005 SHALL have ports in_valid, in_sof, in_eof, in_err, inputs, 1 each: beat valid, first word, last word, frame error (sampled on the eof beat).
REQ-006 SHALL have port in_portmap, input, 4, destination port bitmap (sampled on the sof beat).
REQ-007 SHALL have port in_src_port, input, 2, ingress port index (sampled on the sof beat).
REQ-008 SHALL have port in_ready, output, 1, beat acceptance.
REQ-009 SHALL have port cell_data_din, output, 128, word to the switch core data FIFO.
REQ-010 SHALL have port cell_data_wr, output, 1, data FIFO write strobe.
REQ-011 SHALL have port cell_ptr_din, output, 16, frame descriptor: [15:12]=0, [11:8]=portmap, [7:0]=word count.
REQ-012 SHALL have port cell_ptr_wr, output, 1, descriptor FIFO write strobe.
REQ-013 SHALL have port cell_bp, input, 1, registered back-pressure from the switch core.
REQ-014 SHALL have ports stat_fwd_cnt and stat_drop_cnt, outputs, 16 each: frames forwarded and frames discarded.

Function
REQ-015 in_ready SHALL equal !cell_bp combinationally; a beat is accepted when in_valid && in_ready.
REQ-016 SHALL implement states IDLE, BODY, OVER.
REQ-017 IDLE: an accepted beat with in_sof SHALL latch portmap_eff = in_portmap & ~(4'b1 << in_src_port), set word_cnt=1, write the beat, and go to BODY; with in_sof && in_eof the frame SHALL close in the same cycle and the state SHALL remain IDLE.
REQ-018 IDLE: an accepted beat without in_sof SHALL be dropped silently (no data write, no pointer write, no counter change).
REQ-019 BODY: each accepted beat SHALL be written and word_cnt incremented; a beat that would exceed MAX_WORDS SHALL not be written, the frame SHALL be marked discard, and the state SHALL go to OVER (or close the frame immediately if that beat carries eof).
REQ-020 OVER: accepted beats SHALL not be written; the eof beat SHALL close the frame and return to IDLE.
REQ-021 Frame close SHALL write exactly one descriptor with [7:0]=words actually written; [11:8]=portmap_eff, or 4'b0 if in_err, oversize, or portmap_eff==0 (the switch core consumes and discards portmap-0 frames).
REQ-022 An accepted in_sof beat in BODY or OVER SHALL close the open frame with portmap 4'b0 and start the new frame as in REQ-017, both in the same cycle.
REQ-023 Latency: a beat accepted at edge N SHALL appear as cell_data_wr/cell_data_din at N+1; the closing descriptor SHALL appear at N+1 of the closing beat, never before the frame's last data write.
REQ-024 Outputs SHALL be registered; cell_data_wr and cell_ptr_wr SHALL be single-cycle pulses per beat or per frame.
REQ-025 stat_fwd_cnt SHALL increment on each descriptor with a non-zero portmap; stat_drop_cnt SHALL increment on each zero-portmap descriptor; both SHALL wrap at 16'hFFFF->0.
REQ-026 Back-pressure SHALL only stall acceptance; state, word_cnt and latched portmap SHALL hold while in_ready is low.

Reset
REQ-027 On rstn low: state IDLE; cell_data_wr=0, cell_ptr_wr=0, cell_data_din=0, cell_ptr_din=0; word_cnt=0; both counters 0; an in-flight frame SHALL be abandoned with no descriptor written.
REQ-028 After rstn release the first accepted beat SHALL require in_sof.

Verification
REQ-029 5-word frame, src 0, portmap 4'b0111, no bp -> 5 data writes, then descriptor 16'h0605; stat_fwd_cnt=1.
REQ-030 Single-beat frame (sof+eof), src 2, portmap 4'b0100 -> 1 data write, descriptor 16'h0001; stat_drop_cnt=1.
REQ-031 100-word frame, MAX_WORDS=96 -> 96 data writes, descriptor 16'h0060, stat_drop_cnt incremented.
REQ-032 cell_bp high for 10 cycles mid-frame with in_valid held -> in_ready=0, no writes during the stall, frame completes intact after release.
REQ-033 sof arrives on word 3 of an open frame -> descriptor 16'h0003 (portmap 0) plus correct new-frame handling; in_err on eof -> portmap field 0.
REQ-034 rstn asserted mid-frame -> all outputs 0 immediately; no descriptor is written; next frame is processed normally.
